// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared encodings and constants for the parametrised FP datapath
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [3:0] {
        ST_GET_A, ST_GET_B, ST_UNPACK, ST_SPECIAL, ST_NORM_A, ST_NORM_B, ST_MULT,
        ST_POST, ST_NORM_HI, ST_DENORM, ST_ROUND, ST_PACK, ST_PUT_Z
    } fp_state_t;

    // Positive quiet NaN: exponent all ones, fraction MSB set; callers truncate to W bits.
    function automatic logic [63:0] canon_nan(input int e_w, input int m_w);
        logic [63:0] r;
        r = ((64'(1) << e_w) - 64'(1)) << m_w;
        r = r | (64'(1) << (m_w - 1));
        return r;
    endfunction

    function automatic logic [63:0] max_finite(input int e_w, input int m_w);
        logic [63:0] r;
        r = ((64'(1) << e_w) - 64'(2)) << m_w;
        r = r | ((64'(1) << m_w) - 64'(1));
        return r;
    endfunction

endpackage

// File: rtl/fp_multiplier_param_if.sv
// rtl/fp_multiplier_param_if.sv - operand/result strobe-acknowledge bundle
interface fp_multiplier_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [W-1:0] input_b;
    logic         input_b_stb;
    logic         input_b_ack;
    logic [1:0]   round_mode;
    logic [W-1:0] output_z;
    logic         output_z_stb;
    logic         output_z_ack;
    logic [3:0]   flags;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, round_mode, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb, flags
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, round_mode, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb, flags
    );
endinterface

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - IEEE rounding increment decision from lsb/guard/round/sticky
module fp_round_decide import fp_pkg::*; (
    input  logic [1:0] mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       round,
    input  logic       sticky,
    output logic       increment
);
    always_comb begin
        increment = 1'b0;
        unique case (mode)
            RM_RNE: increment = guard & (round | sticky | lsb);
            RM_RTZ: increment = 1'b0;
            RM_RUP: increment = ~sign & (guard | round | sticky);
            RM_RDN: increment = sign & (guard | round | sticky);
        endcase
    end
endmodule

// File: rtl/fp_multiplier_param.sv
// rtl/fp_multiplier_param.sv - multi-cycle IEEE-754 multiplier with generic exponent/fraction widths
module fp_multiplier_param import fp_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic clk,
    input logic rst,
    fp_multiplier_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(1) - BIAS;
    localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [W-1:0] MAXF = W'(max_finite(EXP_W, MAN_W));
    localparam logic [W-1:0] INFM = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    fp_state_t state, state_next;
    logic [W-1:0] a, b, z_out;
    logic [1:0] rm;
    logic [SW-1:0] a_m, b_m, z_m;
    logic signed [EW-1:0] a_e, b_e, z_e;
    logic a_s, b_s, z_s, guard, round_bit, sticky, tiny, inexact;
    logic a_ack, b_ack, z_stb, round_inc;
    logic [3:0] flg;
    logic [PW-1:0] prod;
    logic [2*SW-1:0] mul_full;
    logic [SW:0] m_inc;
    logic [EXP_W-1:0] a_ef, b_ef, pack_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, is_special;

    assign a_ef   = a[W-2:MAN_W];
    assign b_ef   = b[W-2:MAN_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign a_nan  = (&a_ef) & (|a_frac);
    assign b_nan  = (&b_ef) & (|b_frac);
    assign a_inf  = (&a_ef) & ~(|a_frac);
    assign b_inf  = (&b_ef) & ~(|b_frac);
    assign a_zero = ~(|a_ef) & ~(|a_frac);
    assign b_zero = ~(|b_ef) & ~(|b_frac);
    assign a_snan = a_nan & ~a_frac[MAN_W-1];
    assign b_snan = b_nan & ~b_frac[MAN_W-1];
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign mul_full = (2*SW)'(a_m) * (2*SW)'(b_m);
    assign m_inc    = {1'b0, z_m} + (SW+1)'(1);
    assign pack_exp = z_m[MAN_W] ? EXP_W'(z_e + BIAS) : {EXP_W{1'b0}};

    fp_round_decide u_round (
        .mode(rm), .sign(z_s), .lsb(z_m[0]), .guard(guard),
        .round(round_bit), .sticky(sticky), .increment(round_inc)
    );

    assign bus.input_a_ack  = a_ack;
    assign bus.input_b_ack  = b_ack;
    assign bus.output_z     = z_out;
    assign bus.output_z_stb = z_stb;
    assign bus.flags        = flg;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_GET_A;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_GET_A:   if (a_ack && bus.input_a_stb) state_next = ST_GET_B;
            ST_GET_B:   if (b_ack && bus.input_b_stb) state_next = ST_UNPACK;
            ST_UNPACK:  state_next = ST_SPECIAL;
            ST_SPECIAL: state_next = is_special ? ST_PUT_Z : ST_NORM_A;
            ST_NORM_A:  state_next = a_m[MAN_W] ? ST_NORM_B : ST_NORM_A;
            ST_NORM_B:  state_next = b_m[MAN_W] ? ST_MULT : ST_NORM_B;
            ST_MULT:    state_next = ST_POST;
            ST_POST:    state_next = ST_NORM_HI;
            ST_NORM_HI: state_next = ST_DENORM;
            ST_DENORM:  state_next = (z_e < EMIN) ? ST_DENORM : ST_ROUND;
            ST_ROUND:   state_next = ST_PACK;
            ST_PACK:    state_next = ST_PUT_Z;
            ST_PUT_Z:   if (z_stb && bus.output_z_ack) state_next = ST_GET_A;
            default:    state_next = ST_GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            z_stb <= 1'b0;
            z_out <= '0;
            flg   <= '0;
        end else begin
            case (state)
                ST_GET_A: begin
                    a_ack <= 1'b1;
                    if (a_ack && bus.input_a_stb) begin
                        a     <= bus.input_a;
                        a_ack <= 1'b0;
                    end
                end
                ST_GET_B: begin
                    b_ack <= 1'b1;
                    if (b_ack && bus.input_b_stb) begin
                        b     <= bus.input_b;
                        rm    <= bus.round_mode;
                        b_ack <= 1'b0;
                    end
                end
                ST_UNPACK: begin
                    a_m <= {1'b0, a_frac};
                    b_m <= {1'b0, b_frac};
                    a_e <= $signed({2'b00, a_ef}) - BIAS;
                    b_e <= $signed({2'b00, b_ef}) - BIAS;
                    a_s <= a[W-1];
                    b_s <= b[W-1];
                end
                ST_SPECIAL: begin
                    flg <= '0;
                    if (a_nan || b_nan) begin
                        z_out <= QNAN;
                        flg[FLG_INVALID] <= a_snan | b_snan;
                    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        z_out <= QNAN;
                        flg[FLG_INVALID] <= 1'b1;
                    end else if (a_inf || b_inf) begin
                        z_out <= {a_s ^ b_s, INFM[W-2:0]};
                    end else if (a_zero || b_zero) begin
                        z_out <= {a_s ^ b_s, {(W-1){1'b0}}};
                    end else begin
                        // Subnormals keep the minimum exponent and lack the hidden bit.
                        if (a_ef == '0) a_e <= EMIN;
                        else            a_m[MAN_W] <= 1'b1;
                        if (b_ef == '0) b_e <= EMIN;
                        else            b_m[MAN_W] <= 1'b1;
                    end
                end
                ST_NORM_A: if (!a_m[MAN_W]) begin
                    a_m <= a_m << 1;
                    a_e <= a_e - EW'(1);
                end
                ST_NORM_B: if (!b_m[MAN_W]) begin
                    b_m <= b_m << 1;
                    b_e <= b_e - EW'(1);
                end
                ST_MULT: begin
                    z_e  <= a_e + b_e + EW'(1);
                    prod <= {mul_full, 2'b00};
                    z_s  <= a_s ^ b_s;
                    tiny <= 1'b0;
                end
                ST_POST: begin
                    z_m       <= prod[PW-1 -: SW];
                    guard     <= prod[PW-SW-1];
                    round_bit <= prod[PW-SW-2];
                    sticky    <= |prod[PW-SW-3:0];
                end
                ST_NORM_HI: if (!z_m[MAN_W]) begin
                    z_m       <= {z_m[MAN_W-1:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                    z_e       <= z_e - EW'(1);
                end
                ST_DENORM: if (z_e < EMIN) begin
                    z_m       <= z_m >> 1;
                    z_e       <= z_e + EW'(1);
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                    tiny      <= 1'b1;
                end
                ST_ROUND: begin
                    inexact <= guard | round_bit | sticky;
                    if (round_inc) begin
                        if (m_inc[SW]) begin
                            z_m <= m_inc[SW:1];
                            z_e <= z_e + EW'(1);
                        end else begin
                            z_m <= m_inc[SW-1:0];
                        end
                    end
                end
                ST_PACK: begin
                    flg <= '0;
                    if (z_e > BIAS) begin
                        flg[FLG_OVERFLOW] <= 1'b1;
                        flg[FLG_INEXACT]  <= 1'b1;
                        case (rm)
                            RM_RNE:  z_out <= {z_s, INFM[W-2:0]};
                            RM_RTZ:  z_out <= {z_s, MAXF[W-2:0]};
                            RM_RUP:  z_out <= z_s ? {1'b1, MAXF[W-2:0]} : INFM;
                            default: z_out <= z_s ? {1'b1, INFM[W-2:0]} : MAXF;
                        endcase
                    end else begin
                        z_out <= {z_s, pack_exp, z_m[MAN_W-1:0]};
                        flg[FLG_INEXACT]   <= inexact;
                        flg[FLG_UNDERFLOW] <= tiny & inexact;
                    end
                end
                ST_PUT_Z: begin
                    z_stb <= 1'b1;
                    if (z_stb && bus.output_z_ack) z_stb <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_multiplier_param.sv
// tb/tb_fp_multiplier_param.sv - directed self-checking bench for single and half precision
module tb_fp_multiplier_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_fail = 0;

    fp_multiplier_param_if #(.EXP_W(8), .MAN_W(23)) s_if ();
    fp_multiplier_param_if #(.EXP_W(5), .MAN_W(10)) h_if ();

    fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .bus(s_if));
    fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(h_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_s(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        int n;
        s_if.input_a = a;
        s_if.input_a_stb = 1'b1;
        n = 0;
        while (!s_if.input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
        check("a_ack_rise", s_if.input_a_ack, 1);
        @(posedge clk); #1;
        s_if.input_a_stb = 1'b0;
        s_if.input_b = b;
        s_if.round_mode = rm;
        s_if.input_b_stb = 1'b1;
        n = 0;
        while (!s_if.input_b_ack && n < 50) begin @(posedge clk); #1; n++; end
        check("b_ack_rise", s_if.input_b_ack, 1);
        @(posedge clk); #1;
        s_if.input_b_stb = 1'b0;
    endtask

    task automatic wait_z_s(output int lat);
        lat = 0;
        while (!s_if.output_z_stb && lat < 300) begin @(posedge clk); #1; lat++; end
        check("z_stb_rise", s_if.output_z_stb, 1);
    endtask

    task automatic take_s(output logic [31:0] z, output logic [3:0] f);
        z = s_if.output_z;
        f = s_if.flags;
        s_if.output_z_ack = 1'b1;
        @(posedge clk); #1;
        s_if.output_z_ack = 1'b0;
    endtask

    task automatic run_s(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic [31:0] ez, input logic [3:0] ef);
        logic [31:0] z;
        logic [3:0] f;
        int lat;
        send_s(a, b, rm);
        wait_z_s(lat);
        take_s(z, f);
        check({tag, "_z"}, z, ez);
        check({tag, "_flags"}, f, ef);
    endtask

    initial begin
        logic [31:0] z, z0;
        logic [15:0] zh;
        logic [3:0] f;
        int lat, n, hits;

        s_if.input_a = '0; s_if.input_a_stb = 0; s_if.input_b = '0; s_if.input_b_stb = 0;
        s_if.round_mode = 2'b00; s_if.output_z_ack = 0;
        h_if.input_a = '0; h_if.input_a_stb = 0; h_if.input_b = '0; h_if.input_b_stb = 0;
        h_if.round_mode = 2'b00; h_if.output_z_ack = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ack", s_if.input_a_ack, 0);
        check("rst_b_ack", s_if.input_b_ack, 0);
        check("rst_z_stb", s_if.output_z_stb, 0);
        check("rst_z", s_if.output_z, 0);
        check("rst_flags", s_if.flags, 0);
        rst = 1'b0;

        send_s(32'h4000_0000, 32'h4040_0000, 2'b00);
        wait_z_s(lat);
        check("mul_2x3_latency", lat, 11);
        take_s(z, f);
        check("mul_2x3_z", z, 32'h40C0_0000);
        check("mul_2x3_flags", f, 4'b0000);

        send_s(32'h7F80_0000, 32'h0000_0000, 2'b00);
        wait_z_s(lat);
        check("special_latency", lat, 3);
        take_s(z, f);
        check("inf_x_zero_z", z, 32'h7FC0_0000);
        check("inf_x_zero_flags", f, 4'b1000);

        run_s("zero_x_ninf", 32'h0000_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000, 4'b1000);
        run_s("inf_x_neg2", 32'h7F80_0000, 32'hC000_0000, 2'b00, 32'hFF80_0000, 4'b0000);
        run_s("snan", 32'h7F80_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 4'b1000);
        run_s("qnan", 32'h3F80_0000, 32'h7FC0_0001, 2'b00, 32'h7FC0_0000, 4'b0000);

        run_s("ulp_rne", 32'h3F80_0001, 32'h3F80_0001, 2'b00, 32'h3F80_0002, 4'b0001);
        run_s("ulp_rtz", 32'h3F80_0001, 32'h3F80_0001, 2'b01, 32'h3F80_0002, 4'b0001);
        run_s("ulp_rup", 32'h3F80_0001, 32'h3F80_0001, 2'b10, 32'h3F80_0003, 4'b0001);
        run_s("ulp_rdn", 32'h3F80_0001, 32'h3F80_0001, 2'b11, 32'h3F80_0002, 4'b0001);

        run_s("ovf_rne", 32'h7F7F_FFFF, 32'h4000_0000, 2'b00, 32'h7F80_0000, 4'b0101);
        run_s("ovf_rtz", 32'h7F7F_FFFF, 32'h4000_0000, 2'b01, 32'h7F7F_FFFF, 4'b0101);

        run_s("minnorm_half", 32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0040_0000, 4'b0000);
        run_s("minsub_half", 32'h0000_0001, 32'h3F00_0000, 2'b00, 32'h0000_0000, 4'b0011);

        // Half-precision instance
        h_if.input_a = 16'h4000; h_if.input_a_stb = 1'b1;
        n = 0;
        while (!h_if.input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
        check("h_a_ack_rise", h_if.input_a_ack, 1);
        @(posedge clk); #1;
        h_if.input_a_stb = 1'b0;
        h_if.input_b = 16'h4200; h_if.input_b_stb = 1'b1;
        n = 0;
        while (!h_if.input_b_ack && n < 50) begin @(posedge clk); #1; n++; end
        check("h_b_ack_rise", h_if.input_b_ack, 1);
        @(posedge clk); #1;
        h_if.input_b_stb = 1'b0;
        n = 0;
        while (!h_if.output_z_stb && n < 300) begin @(posedge clk); #1; n++; end
        check("h_latency", n, 11);
        zh = h_if.output_z;
        check("h_2x3_z", zh, 16'h4600);
        check("h_2x3_flags", h_if.flags, 4'b0000);
        h_if.output_z_ack = 1'b1;
        @(posedge clk); #1;
        h_if.output_z_ack = 1'b0;
        check("h_z_stb_drop", h_if.output_z_stb, 0);

        // Result held while the consumer stalls
        send_s(32'h4000_0000, 32'h4040_0000, 2'b00);
        wait_z_s(lat);
        z0 = s_if.output_z;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (s_if.output_z_stb && s_if.output_z === z0) hits++;
        end
        check("stall_hold_cycles", hits, 5);
        check("stall_z", z0, 32'h40C0_0000);
        s_if.output_z_ack = 1'b1;
        @(posedge clk); #1;
        s_if.output_z_ack = 1'b0;
        check("stall_stb_drop", s_if.output_z_stb, 0);

        // Reset while the subnormal operand is being normalised
        send_s(32'h0000_0001, 32'h3F80_0000, 2'b00);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_a_ack", s_if.input_a_ack, 0);
        check("midrst_b_ack", s_if.input_b_ack, 0);
        check("midrst_z_stb", s_if.output_z_stb, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (s_if.output_z_stb) hits++;
        end
        check("midrst_no_result", hits, 0);
        run_s("after_rst", 32'h4000_0000, 32'h4040_0000, 2'b00, 32'h40C0_0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
